// File: rtl/ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// ctrl_pkg: shared state, class and control encodings for multicycle_control
// Rev 1.0
// ----------------------------------------------------------------------
package ctrl_pkg;

  localparam int OPCODE_BITS = 11;
  localparam int CLASS_W     = 4;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [CLASS_W-1:0] {
    CL_NONE  = 4'd0,
    CL_ADDI  = 4'd1,
    CL_ADDS  = 4'd2,
    CL_AND   = 4'd3,
    CL_XOR   = 4'd4,
    CL_SUBS  = 4'd5,
    CL_LSR   = 4'd6,
    CL_LDUR  = 4'd7,
    CL_STUR  = 4'd8,
    CL_B     = 4'd9,
    CL_BL    = 4'd10,
    CL_BR    = 4'd11,
    CL_BCOND = 4'd12,
    CL_CBZ   = 4'd13
  } iclass_e;

  localparam logic [2:0] ALU_PASS_B = 3'd0;
  localparam logic [2:0] ALU_LSR    = 3'd1;
  localparam logic [2:0] ALU_ADD    = 3'd2;
  localparam logic [2:0] ALU_SUB    = 3'd3;
  localparam logic [2:0] ALU_AND    = 3'd4;
  localparam logic [2:0] ALU_XOR    = 3'd6;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_REG    = 2'd2;

  localparam logic [1:0] IMM_DT    = 2'd0;
  localparam logic [1:0] IMM_ALU   = 2'd1;
  localparam logic [1:0] IMM_SHAMT = 2'd2;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_IMEM    = 2'd2;
  localparam logic [1:0] TRAP_DMEM    = 2'd3;

  // Branch formats only fix the leading opcode bits; the rest is offset/cond.
  function automatic iclass_e classify(input logic [OPCODE_BITS-1:0] op);
    iclass_e cls;
    casez (op)
      11'b1001000100?: cls = CL_ADDI;
      11'b10101011000: cls = CL_ADDS;
      11'b10001010000: cls = CL_AND;
      11'b11001010000: cls = CL_XOR;
      11'b11101011000: cls = CL_SUBS;
      11'b11010011010: cls = CL_LSR;
      11'b11111000010: cls = CL_LDUR;
      11'b11111000000: cls = CL_STUR;
      11'b000101?????: cls = CL_B;
      11'b100101?????: cls = CL_BL;
      11'b11010110000: cls = CL_BR;
      11'b01010100???: cls = CL_BCOND;
      11'b10110100???: cls = CL_CBZ;
      default:         cls = CL_NONE;
    endcase
    return cls;
  endfunction

  function automatic logic is_rtype(input iclass_e cls);
    return cls inside {CL_ADDS, CL_AND, CL_XOR, CL_SUBS, CL_LSR};
  endfunction

endpackage
`default_nettype wire

// File: rtl/opcode_class_dec.sv
`default_nettype none
// ----------------------------------------------------------------------
// opcode_class_dec: maps the 11-bit opcode field to an instruction class
// Rev 1.0
// ----------------------------------------------------------------------
module opcode_class_dec
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 11
) (
  input  logic [OPCODE_W-1:0] opcode,
  output logic [CLASS_W-1:0]  op_class,
  output logic                valid
);

  iclass_e cls;

  always_comb begin
    cls      = classify(opcode);
    op_class = cls;
    valid    = (cls != CL_NONE);
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ----------------------------------------------------------------------
// multicycle_control: LEGv8 FETCH/DECODE/EXEC/MEM/WB sequencer with traps
// Rev 1.0
// ----------------------------------------------------------------------
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 11,
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic               ir_valid,
  output logic               imem_req,
  input  logic               imem_ack,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  output logic               ir_load,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  input  logic               branch_taken,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src,
  output logic [1:0]         imm_sel,
  output logic               reg2loc,
  output logic               set_flags,
  output logic               mem_to_reg,
  output logic               pc_to_reg,
  output logic               link_reg,
  output logic               reg_write,
  output logic               instr_done,
  output logic               trap,
  output logic [1:0]         trap_cause
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  iclass_e            cls_q, cls_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         cause_q, cause_d;

  logic [CLASS_W-1:0] dec_class_raw;
  iclass_e            dec_class;
  logic               dec_valid;
  logic               timeout_hit;

  opcode_class_dec #(
    .OPCODE_W (OPCODE_W)
  ) u_dec (
    .opcode   (opcode),
    .op_class (dec_class_raw),
    .valid    (dec_valid)
  );

  assign dec_class   = iclass_e'(dec_class_raw);
  assign timeout_hit = (cnt_q == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      cls_q   <= CL_NONE;
      cnt_q   <= '0;
      cause_q <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    cause_d = cause_q;
    case (state_q)
      ST_FETCH: begin
        // An ack on the last allowed cycle still completes the fetch.
        if (imem_ack) begin
          state_d = ST_DECODE;
        end else if (timeout_hit) begin
          state_d = ST_TRAP;
          cause_d = TRAP_IMEM;
        end
      end
      ST_DECODE: begin
        if (ir_valid) begin
          cls_d = dec_class;
          if (dec_valid) begin
            state_d = ST_EXEC;
          end else begin
            state_d = ST_TRAP;
            cause_d = TRAP_ILLEGAL;
          end
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CL_B, CL_BR, CL_BCOND, CL_CBZ: state_d = ST_FETCH;
          CL_LDUR, CL_STUR:              state_d = ST_MEM;
          default:                       state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack) begin
          state_d = (cls_q == CL_STUR) ? ST_FETCH : ST_WB;
        end else if (timeout_hit) begin
          state_d = ST_TRAP;
          cause_d = TRAP_DMEM;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase

    // Counter restarts on every state entry and only advances while waiting on a bus.
    cnt_d = '0;
    if ((state_q == ST_FETCH || state_q == ST_MEM) && state_d == state_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    alu_op     = ALUOP_W'(ALU_PASS_B);
    alu_src    = 1'b0;
    imm_sel    = IMM_DT;
    reg2loc    = 1'b0;
    set_flags  = 1'b0;
    mem_to_reg = 1'b0;
    pc_to_reg  = 1'b0;
    link_reg   = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    trap       = 1'b0;
    trap_cause = TRAP_NONE;
    // Outputs are held quiet for as long as reset is asserted.
    if (reset_n) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          ir_load  = imem_ack;
        end
        ST_DECODE: reg2loc = ir_valid && is_rtype(dec_class);
        ST_EXEC: begin
          case (cls_q)
            CL_ADDI: begin
              alu_op  = ALUOP_W'(ALU_ADD);
              alu_src = 1'b1;
              imm_sel = IMM_ALU;
            end
            CL_ADDS: begin
              alu_op    = ALUOP_W'(ALU_ADD);
              set_flags = 1'b1;
            end
            CL_AND: alu_op = ALUOP_W'(ALU_AND);
            CL_XOR: alu_op = ALUOP_W'(ALU_XOR);
            CL_SUBS: begin
              alu_op    = ALUOP_W'(ALU_SUB);
              set_flags = 1'b1;
            end
            CL_LSR: begin
              alu_op  = ALUOP_W'(ALU_LSR);
              alu_src = 1'b1;
              imm_sel = IMM_SHAMT;
            end
            CL_LDUR, CL_STUR: begin
              alu_op  = ALUOP_W'(ALU_ADD);
              alu_src = 1'b1;
              imm_sel = IMM_DT;
            end
            CL_B, CL_BR, CL_BCOND, CL_CBZ: begin
              pc_write   = 1'b1;
              instr_done = 1'b1;
              if (cls_q == CL_B)       pc_src = PC_BRANCH;
              else if (cls_q == CL_BR) pc_src = PC_REG;
              else                     pc_src = branch_taken ? PC_BRANCH : PC_PLUS4;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == CL_STUR);
          if (dmem_ack && cls_q == CL_STUR) begin
            pc_write   = 1'b1;
            instr_done = 1'b1;
          end
        end
        ST_WB: begin
          reg_write  = 1'b1;
          pc_write   = 1'b1;
          instr_done = 1'b1;
          mem_to_reg = (cls_q == CL_LDUR);
          if (cls_q == CL_BL) begin
            pc_to_reg = 1'b1;
            link_reg  = 1'b1;
            pc_src    = PC_BRANCH;
          end
        end
        ST_TRAP: begin
          trap       = 1'b1;
          trap_cause = cause_q;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_multicycle_control: directed cycle-by-cycle bench for multicycle_control
// Rev 1.0
// ----------------------------------------------------------------------
module tb_multicycle_control;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_load;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       alu_src;
    logic [1:0] imm_sel;
    logic       reg2loc;
    logic       set_flags;
    logic       mem_to_reg;
    logic       pc_to_reg;
    logic       link_reg;
    logic       reg_write;
    logic       instr_done;
    logic       trap;
    logic [1:0] trap_cause;
  } ctl_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] opcode;
  logic        ir_valid;
  logic        imem_req, imem_ack;
  logic        dmem_req, dmem_we, dmem_ack;
  logic        ir_load, pc_write;
  logic [1:0]  pc_src;
  logic        branch_taken;
  logic [2:0]  alu_op;
  logic        alu_src;
  logic [1:0]  imm_sel;
  logic        reg2loc, set_flags, mem_to_reg, pc_to_reg, link_reg;
  logic        reg_write, instr_done, trap;
  logic [1:0]  trap_cause;

  ctl_t obs;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_control #(
    .OPCODE_W    (11),
    .ALUOP_W     (3),
    .MEM_TIMEOUT (16),
    .CNT_W       (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .opcode       (opcode),
    .ir_valid     (ir_valid),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ack     (dmem_ack),
    .ir_load      (ir_load),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .alu_op       (alu_op),
    .alu_src      (alu_src),
    .imm_sel      (imm_sel),
    .reg2loc      (reg2loc),
    .set_flags    (set_flags),
    .mem_to_reg   (mem_to_reg),
    .pc_to_reg    (pc_to_reg),
    .link_reg     (link_reg),
    .reg_write    (reg_write),
    .instr_done   (instr_done),
    .trap         (trap),
    .trap_cause   (trap_cause)
  );

  assign obs = {imem_req, dmem_req, dmem_we, ir_load, pc_write, pc_src, alu_op, alu_src,
                imm_sel, reg2loc, set_flags, mem_to_reg, pc_to_reg, link_reg, reg_write,
                instr_done, trap, trap_cause};

  // Leaves the bench at posedge+1 with reset released and the DUT in FETCH.
  task automatic do_reset;
    reset_n      = 1'b0;
    imem_ack     = 1'b0;
    dmem_ack     = 1'b0;
    branch_taken = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    ctl_t e;
    reset_n = 1'b0; opcode = '0; ir_valid = 1'b1;
    imem_ack = 1'b1; dmem_ack = 1'b1; branch_taken = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_first: got %h expected %h", obs, 23'h0); end
    @(posedge clk); #1;
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", obs, 23'h0); end
    imem_ack = 1'b0; dmem_ack = 1'b0; reset_n = 1'b1;
    #1;
    e = '0; e.imem_req = 1'b1;
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_release: got %h expected %h", obs, e); end
  endtask

  task automatic test_addi;
    ctl_t e [0:5];
    logic ia [0:5] = '{0, 1, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) e[i] = '0;
    e[0].imem_req = 1;
    e[1].imem_req = 1; e[1].ir_load = 1;
    e[3].alu_op = 3'd2; e[3].alu_src = 1; e[3].imm_sel = 2'd1;
    e[4].reg_write = 1; e[4].pc_write = 1; e[4].instr_done = 1;
    e[5].imem_req = 1;
    do_reset();
    opcode = 11'b10010001000;
    for (int i = 0; i < 6; i++) begin
      imem_ack = ia[i]; #1;
      n_checks++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL addi cyc%0d: got %h expected %h", i, obs, e[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_subs;
    ctl_t e [0:4];
    logic ia [0:4] = '{1, 0, 0, 0, 0};
    for (int i = 0; i < 5; i++) e[i] = '0;
    e[0].imem_req = 1; e[0].ir_load = 1;
    e[1].reg2loc = 1;
    e[2].alu_op = 3'd3; e[2].set_flags = 1;
    e[3].reg_write = 1; e[3].pc_write = 1; e[3].instr_done = 1;
    e[4].imem_req = 1;
    do_reset();
    opcode = 11'b11101011000;
    for (int i = 0; i < 5; i++) begin
      imem_ack = ia[i]; #1;
      n_checks++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL subs cyc%0d: got %h expected %h", i, obs, e[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ldur;
    ctl_t e [0:8];
    logic ia [0:8] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    logic da [0:8] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 9; i++) e[i] = '0;
    e[0].imem_req = 1; e[0].ir_load = 1;
    e[2].alu_op = 3'd2; e[2].alu_src = 1; e[2].imm_sel = 2'd0;
    for (int i = 3; i <= 6; i++) e[i].dmem_req = 1;
    e[7].reg_write = 1; e[7].pc_write = 1; e[7].instr_done = 1; e[7].mem_to_reg = 1;
    e[8].imem_req = 1;
    do_reset();
    opcode = 11'b11111000010;
    for (int i = 0; i < 9; i++) begin
      imem_ack = ia[i]; dmem_ack = da[i]; #1;
      n_checks++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL ldur cyc%0d: got %h expected %h", i, obs, e[i]); end
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
  endtask

  task automatic test_cbz_back_to_back;
    ctl_t e [0:6];
    logic ia [0:6] = '{1, 0, 0, 1, 0, 0, 0};
    logic bt [0:6] = '{0, 0, 1, 1, 1, 0, 1};
    for (int i = 0; i < 7; i++) e[i] = '0;
    e[0].imem_req = 1; e[0].ir_load = 1;
    e[2].pc_write = 1; e[2].pc_src = 2'd1; e[2].instr_done = 1;
    e[3].imem_req = 1; e[3].ir_load = 1;
    e[5].pc_write = 1; e[5].pc_src = 2'd0; e[5].instr_done = 1;
    e[6].imem_req = 1;
    do_reset();
    opcode = 11'b10110100101;
    for (int i = 0; i < 7; i++) begin
      imem_ack = ia[i]; branch_taken = bt[i]; #1;
      n_checks++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL cbz cyc%0d: got %h expected %h", i, obs, e[i]); end
      @(posedge clk); #1;
    end
    branch_taken = 1'b0;
  endtask

  task automatic test_bl;
    ctl_t e [0:4];
    logic ia [0:4] = '{1, 0, 0, 0, 0};
    for (int i = 0; i < 5; i++) e[i] = '0;
    e[0].imem_req = 1; e[0].ir_load = 1;
    e[3].reg_write = 1; e[3].pc_write = 1; e[3].instr_done = 1;
    e[3].pc_to_reg = 1; e[3].link_reg = 1; e[3].pc_src = 2'd1;
    e[4].imem_req = 1;
    do_reset();
    opcode = 11'b10010111111;
    for (int i = 0; i < 5; i++) begin
      imem_ack = ia[i]; #1;
      n_checks++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL bl cyc%0d: got %h expected %h", i, obs, e[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal;
    ctl_t e [0:7];
    logic ia [0:7] = '{1, 0, 1, 1, 0, 1, 0, 1};
    logic da [0:7] = '{0, 0, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < 8; i++) e[i] = '0;
    e[0].imem_req = 1; e[0].ir_load = 1;
    for (int i = 2; i < 8; i++) begin e[i].trap = 1; e[i].trap_cause = 2'd1; end
    do_reset();
    opcode = 11'b00000000000;
    for (int i = 0; i < 8; i++) begin
      imem_ack = ia[i]; dmem_ack = da[i]; #1;
      n_checks++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL illegal cyc%0d: got %h expected %h", i, obs, e[i]); end
      @(posedge clk); #1;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic test_imem_timeout;
    ctl_t e [0:17];
    for (int i = 0; i < 18; i++) e[i] = '0;
    for (int i = 0; i < 16; i++) e[i].imem_req = 1;
    for (int i = 16; i < 18; i++) begin e[i].trap = 1; e[i].trap_cause = 2'd2; end
    do_reset();
    opcode = 11'b10010001000;
    for (int i = 0; i < 18; i++) begin
      imem_ack = (i == 17); #1;
      n_checks++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL imem_timeout cyc%0d: got %h expected %h", i, obs, e[i]); end
      @(posedge clk); #1;
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_stur_timeout;
    ctl_t e [0:20];
    for (int i = 0; i < 21; i++) e[i] = '0;
    e[0].imem_req = 1; e[0].ir_load = 1;
    e[2].alu_op = 3'd2; e[2].alu_src = 1;
    for (int i = 3; i <= 18; i++) begin e[i].dmem_req = 1; e[i].dmem_we = 1; end
    for (int i = 19; i <= 20; i++) begin e[i].trap = 1; e[i].trap_cause = 2'd3; end
    do_reset();
    opcode = 11'b11111000000;
    for (int i = 0; i < 21; i++) begin
      imem_ack = (i == 0); dmem_ack = (i == 20); #1;
      n_checks++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL stur_timeout cyc%0d: got %h expected %h", i, obs, e[i]); end
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
  endtask

  task automatic test_stur_ack_last;
    ctl_t e [0:19];
    for (int i = 0; i < 20; i++) e[i] = '0;
    e[0].imem_req = 1; e[0].ir_load = 1;
    e[2].alu_op = 3'd2; e[2].alu_src = 1;
    for (int i = 3; i <= 18; i++) begin e[i].dmem_req = 1; e[i].dmem_we = 1; end
    e[18].pc_write = 1; e[18].instr_done = 1;
    e[19].imem_req = 1;
    do_reset();
    opcode = 11'b11111000000;
    for (int i = 0; i < 20; i++) begin
      imem_ack = (i == 0); dmem_ack = (i == 18); #1;
      n_checks++;
      if (obs !== e[i]) begin n_fail++; $display("FAIL stur_ack16 cyc%0d: got %h expected %h", i, obs, e[i]); end
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_mem;
    ctl_t e;
    do_reset();
    opcode = 11'b11111000000;
    imem_ack = 1'b1;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    e = '0; e.dmem_req = 1; e.dmem_we = 1;
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL midmem_in_mem: got %h expected %h", obs, e); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    dmem_ack = 1'b1;
    #1;
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL midmem_reset: got %h expected %h", obs, 23'h0); end
    reset_n = 1'b1;
    #1;
    e = '0; e.imem_req = 1;
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL midmem_fetch: got %h expected %h", obs, e); end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    #1;
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL midmem_late_ack: got %h expected %h", obs, e); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addi();
    test_subs();
    test_ldur();
    test_cbz_back_to_back();
    test_bl();
    test_illegal();
    test_imem_timeout();
    test_stur_timeout();
    test_stur_ack_last();
    test_reset_mid_mem();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle control sequencer for the LEGv8 datapath. It replaces single-cycle decode with a registered FSM that runs FETCH/DECODE/EXEC/MEM/WB, and handshakes with instruction and data memories of variable latency. It decodes the same opcode set (ADDI, ADDS, AND, XOR, SUBS, LSR, LDUR, STUR, B, BL, BR, B.cond, CBZ) into per-state control pulses. New over the single-cycle decoder: memory handshakes, a timeout trap, illegal-opcode trap, and X-free outputs.

Parameters:
OPCODE_W, 11, opcode field width (instr[31:21])
ALUOP_W, 3, ALU operation select width
MEM_TIMEOUT, 16, cycles waiting for imem_ack/dmem_ack before bus-error trap; legal range 2..255
CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > MEM_TIMEOUT

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
opcode  in  OPCODE_W  instr[31:21], valid while ir_valid=1
ir_valid  in  1  instruction register holds fetched word
imem_req  out  1  instruction fetch request, held until imem_ack
imem_ack  in  1  fetch complete; may arrive 1..n cycles after imem_req
dmem_req  out  1  data access request, held until dmem_ack
dmem_we  out  1  1=store (STUR), 0=load; valid with dmem_req
dmem_ack  in  1  data access complete
ir_load  out  1  one-cycle pulse: latch fetched word into IR
pc_write  out  1  one-cycle pulse: update PC
pc_src  out  2  0=PC+4, 1=PC+branch offset, 2=register (BR)
branch_taken  in  1  datapath condition result (zero flag / cond match), sampled in EXEC
alu_op  out  ALUOP_W  0=pass B, 1=LSR, 2=ADD, 3=SUB, 4=AND, 6=XOR
alu_src  out  1  0=register B, 1=immediate/offset
imm_sel  out  2  0=DT_address, 1=ALU_imm12, 2=shamt
reg2loc  out  1  read-port-2 select (1=Rm, 0=Rt)
set_flags  out  1  flag register write enable, EXEC only
mem_to_reg  out  1  WB mux: 1=load data
pc_to_reg  out  1  WB mux: 1=PC+4 (BL)
link_reg  out  1  write address forced to X30
reg_write  out  1  one-cycle pulse in WB
instr_done  out  1  one-cycle pulse on retire (same cycle as pc_write)
trap  out  1  sticky; FSM halted
trap_cause  out  2  0=none, 1=illegal opcode, 2=imem timeout, 3=dmem timeout

Behaviour:
- Reset (reset_n=0 at posedge): state=FETCH, counter=0, trap=0, trap_cause=0. Every output is 0, with no X on any output in any state. Reset mid-operation drops outstanding req the next cycle; any late ack is ignored.
- FETCH: imem_req=1. imem_ack -> ir_load=1 that cycle, then DECODE. A fetch completes in 1 + ack latency cycles.
- DECODE (1 cycle): classify opcode. Unrecognised -> TRAP, trap_cause=1. reg2loc is valid here: 1 for R-type, 0 for STUR/CBZ/B.cond/BR.
- EXEC (1 cycle): alu_op, alu_src and imm_sel are valid. set_flags=1 for ADDS/SUBS.
  - B: pc_write=1, pc_src=1, instr_done=1 -> FETCH.
  - BR: pc_src=2, same as B.
  - CBZ/B.cond: pc_write=1, pc_src=branch_taken?1:0, instr_done=1 -> FETCH.
  - LDUR/STUR -> MEM.
  - ALU ops and BL -> WB.
- MEM: dmem_req=1; dmem_we=1 for STUR. On ack, STUR retires (pc_write, pc_src=0, instr_done) -> FETCH; LDUR -> WB.
- WB (1 cycle): reg_write=1, pc_write=1, instr_done=1. mem_to_reg=1 for LDUR. BL: pc_to_reg=1, link_reg=1, pc_src=1.
- CPI: ALU ops 4 + fetch latency; branches 3 + fetch latency; LDUR 5 + both latencies.
- Timeout: the counter clears on state entry and increments each cycle in FETCH/MEM without ack. When counter==MEM_TIMEOUT-1 and there is no ack, enter TRAP (cause 2 or 3). Ack and the timeout edge in the same cycle: ack wins.
- TRAP: all pulse outputs 0, req deasserted, trap=1. Only reset exits.
- Acks arriving outside FETCH/MEM are ignored.

Decomposition:
- Shared package ctrl_pkg: state enum, instr class enum, alu_op encodings, pc_src/imm_sel/trap_cause constants, opcode casez patterns.
- One combinational sub-module, opcode_class_dec: opcode -> {class, valid}. The FSM consumes the class, not raw bits.

Test Plan:
- ADDI (opcode 10010001000), imem_ack after 1 cycle -> ir_load at cycle 1, alu_op=2/alu_src=1/imm_sel=1 in EXEC, reg_write+instr_done at cycle 4; no X on any output.
- LDUR (11111000010), dmem_ack delayed 3 cycles -> dmem_req held 4 cycles with dmem_we=0, then WB with mem_to_reg=1, reg_write=1.
- CBZ (10110100xxx) with branch_taken=1, then again with 0 -> pc_src=1 then 0, pc_write pulse in EXEC, reg_write never 1.
- BL (100101xxxxx) -> WB cycle has pc_to_reg=1, link_reg=1, pc_src=1, reg_write=1.
- Opcode 00000000000 -> trap=1, trap_cause=1 one cycle after DECODE; no further imem_req until reset_n=0.
- MEM_TIMEOUT=16 with dmem_ack withheld on STUR -> trap_cause=3 after 16 cycles in MEM. Repeat with ack on cycle 16 -> normal retire. Then reset_n=0 mid-MEM -> all outputs 0 next cycle, FETCH afterward.
